pwm_ramp_ctrl: RTL

//  Per-axis trapezoidal speed-profile stage that sits between the AHB register bank and one

---
 rtl/ramp_pkg.sv | 15 +
 rtl/pwm_ramp_ctrl_if.sv | 28 ++
 rtl/ramp_period_step.sv | 27 ++
 rtl/pwm_ramp_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/ramp_pkg.sv
// rtl/ramp_pkg.sv - shared widths and phase encodings for the trapezoidal PWM ramp stage
package ramp_pkg;

    localparam int DEF_PW  = 32;
    localparam int PHASE_W = 3;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam phase_t IDLE   = 3'd0;
    localparam phase_t ACCEL  = 3'd1;
    localparam phase_t CRUISE = 3'd2;
    localparam phase_t DECEL  = 3'd3;
    localparam phase_t DONE   = 3'd4;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - command/status bundle between the register bank (master) and the ramp stage (slave)
interface pwm_ramp_ctrl_if
    import ramp_pkg::*;
#(
    parameter int PW = DEF_PW
);
    logic               start;
    logic               stop;
    logic [PW-1:0]      pnum;
    logic [PW-1:0]      start_period;
    logic [PW-1:0]      target_period;
    logic [PW-1:0]      accel_step;
    logic               busy;
    logic               done;
    logic               fault;
    logic [PHASE_W-1:0] phase;
    logic [PW-1:0]      pulse_cnt;

    modport master (
        output start, stop, pnum, start_period, target_period, accel_step,
        input  busy, done, fault, phase, pulse_cnt
    );

    modport slave (
        input  start, stop, pnum, start_period, target_period, accel_step,
        output busy, done, fault, phase, pulse_cnt
    );
endinterface

// File: rtl/ramp_period_step.sv
// rtl/ramp_period_step.sv - one clamped period step: min(cur+step, bound) when up, max(cur-step, bound) when down
module ramp_period_step
    import ramp_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          up,
    input  logic [PW-1:0] cur,
    input  logic [PW-1:0] step,
    input  logic [PW-1:0] bound,
    output logic [PW-1:0] nxt
);
    logic [PW:0] sum;
    logic [PW:0] diff;

    // One extra bit catches carry on the way up and borrow on the way down.
    always_comb begin
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        nxt  = bound;
        if (up) begin
            if (sum < {1'b0, bound}) nxt = sum[PW-1:0];
        end else begin
            if (!diff[PW] && (diff[PW-1:0] > bound)) nxt = diff[PW-1:0];
        end
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - trapezoidal period ramp for one OnePWM channel; RAMP_SOFT_STOP_EN turns stop into a ramp-down
module pwm_ramp_ctrl
    import ramp_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic             Clk100m,
    input  logic             Rstn,
    pwm_ramp_ctrl_if.slave   cmd,
    input  logic             pwm_fb,
    input  logic             limit,
    output logic [PW-1:0]    freq_out
);
    phase_t        state;
    logic          pwm_fb_q;
    logic [PW-1:0] pnum_q, start_q, target_q, step_q;
    logic [PW-1:0] cur, cnt, acc_cnt;
    logic          fault_q, done_q;

    logic          fb_edge, decel_hit;
    logic [PW-1:0] cnt_inc, acc_inc, acc_after, step_nxt;

    assign fb_edge   = pwm_fb & ~pwm_fb_q;
    assign cnt_inc   = cnt + PW'(1);
    assign acc_inc   = acc_cnt + PW'(1);
    assign acc_after = (state == ACCEL) ? acc_inc : acc_cnt;
    // Only evaluated when cnt_inc < pnum_q, so the subtraction cannot wrap.
    assign decel_hit = (pnum_q - cnt_inc) <= acc_after;

    ramp_period_step #(.PW(PW)) u_step (
        .up    (state == DECEL),
        .cur   (cur),
        .step  (step_q),
        .bound ((state == DECEL) ? start_q : target_q),
        .nxt   (step_nxt)
    );

    always_ff @(posedge Clk100m or negedge Rstn) begin
        if (!Rstn) begin
            state    <= IDLE;
            pwm_fb_q <= 1'b0;
            pnum_q   <= '0;
            start_q  <= '0;
            target_q <= '0;
            step_q   <= '0;
            cur      <= '0;
            cnt      <= '0;
            acc_cnt  <= '0;
            fault_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            pwm_fb_q <= pwm_fb;
            done_q   <= (state == DONE);
            case (state)
                IDLE: begin
                    if (cmd.start) begin
                        pnum_q   <= cmd.pnum;
                        start_q  <= cmd.start_period;
                        target_q <= cmd.target_period;
                        step_q   <= cmd.accel_step;
                        cnt      <= '0;
                        acc_cnt  <= '0;
                        fault_q  <= 1'b0;
                        cur      <= cmd.start_period;
                        if (cmd.pnum == '0) begin
                            state <= DONE;
                        end else if ((cmd.accel_step == '0) ||
                                     (cmd.start_period <= cmd.target_period)) begin
                            cur   <= cmd.target_period;
                            state <= CRUISE;
                        end else begin
                            state <= ACCEL;
                        end
                    end
                end
                ACCEL, CRUISE, DECEL: begin
                    if (!limit) begin
                        state   <= IDLE;
                        fault_q <= 1'b1;
                        cur     <= start_q;
                    end else if (cmd.stop && (state != DECEL)) begin
`ifdef RAMP_SOFT_STOP_EN
                        // Mirror the ramp-up; a move that never ramped has nothing to unwind.
                        pnum_q <= cnt + acc_cnt;
                        state  <= (acc_cnt == '0) ? DONE : DECEL;
`else
                        state <= IDLE;
                        cur   <= start_q;
`endif
                    end else if (fb_edge) begin
                        cnt <= cnt_inc;
                        if (state != CRUISE) cur <= step_nxt;
                        if (state == ACCEL) acc_cnt <= acc_inc;
                        if (cnt_inc == pnum_q)
                            state <= DONE;
                        else if ((state != DECEL) && decel_hit)
                            state <= DECEL;
                        else if ((state == ACCEL) && (step_nxt == target_q))
                            state <= CRUISE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign freq_out      = cur;
    assign cmd.busy      = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
    assign cmd.done      = done_q;
    assign cmd.fault     = fault_q;
    assign cmd.phase     = state;
    assign cmd.pulse_cnt = cnt;
endmodule
